shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Command-driven controller for the 8-bit left/right shift register.
//  Accepts {data, direction, count} on a valid/ready port and runs the sequence:
//    1. parallel-load data;
//    2. shift count times;
//    3. return the result on a valid/ready response port.
//  Between commands it holds register contents by reloading sr_q every cycle.
//  Sits between the bus/host logic and one shift register instance.
// PARAMETERS
//  WIDTH   8  data width of the controlled shift register
//  CNT_W   4  width of cmd_count; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk                  in   1        single clock, rising edge
//  reset                in   1        asynchronous, active-low reset
//  cmd_valid            in   1        command offered
//  cmd_ready            out  1        controller can accept a command
//  cmd_data             in   WIDTH    value to parallel-load
//  cmd_dir              in   1        0 = shift left, 1 = shift right
//  cmd_count            in   CNT_W    number of shifts; 0..WIDTH, larger values clamped to WIDTH
//  rsp_valid            out  1        result available
//  rsp_ready            in   1        result consumed
//  rsp_data             out  WIDTH    shift-register contents after the sequence
//  busy                 out  1        high from the accept edge until the response handshake
//  sr_load_enable       out  1        1 = parallel load sr_i, 0 = shift one position
//  sr_left_right_shift  out  1        shift direction to register (0 left, 1 right)
//  sr_i                 out  WIDTH    parallel-load data to register
//  sr_q                 in   WIDTH    register output
// BEHAVIOUR
//  - Shift-register contract: load_enable=1 loads i on clk rise; load_enable=0 shifts one bit per edge.
//    The vacated bit fills with 0.
//  - FSM states: IDLE, LOAD, SHIFT, RESP. Moore outputs, decoded from registered state and counter.
//  - IDLE: cmd_ready=1 (forced 0 while reset low); sr_load_enable=1; sr_i=sr_q (hold); busy=0.
//    cmd_valid&cmd_ready on an edge latches data/dir/clamped count -> LOAD.
//  - LOAD (1 cycle): sr_load_enable=1, sr_i=latched data. Next: SHIFT if count>0, else RESP.
//  - SHIFT: sr_load_enable=0, sr_left_right_shift=latched dir; counter decrements each edge.
//    Lasts exactly count cycles, then -> RESP.
//  - RESP: rsp_valid=1, rsp_data=sr_q, hold via reload (sr_i=sr_q, load=1).
//    rsp_valid&rsp_ready -> IDLE. Hold any number of cycles while rsp_ready=0; rsp_data stays stable.
//  - Latency: rsp_valid rises count+1 edges after the accepting edge (count=0 -> 1 edge).
//  - Throughput: a new command can be accepted no earlier than the edge after the response handshake.
//    cmd_ready is low in LOAD/SHIFT/RESP.
//  - sr_left_right_shift is don't-care outside SHIFT; drive the latched dir to avoid toggling.
//  - rsp_data is 0 outside RESP.
//  - Reset (async, any state, including mid-SHIFT): state=IDLE, counter=0, latched regs=0,
//    rsp_valid=0, busy=0, cmd_ready=0 until reset deasserts.
//    Partial shift results are discarded; no response is issued.
//  - Clamp: cmd_count > WIDTH is treated as WIDTH, so the result is all zeros.
//  - cmd_data/cmd_dir/cmd_count changes after the accept edge have no effect.
// STRUCTURE
//  - shift_seq_pkg: state encodings (ST_IDLE/ST_LOAD/ST_SHIFT/ST_RESP), DIR_LEFT=0, DIR_RIGHT=1.
//  - One sub-module, shift_seq_counter: CNT_W down-counter with load, clamp-to-WIDTH and zero flag.
//  - Top: state register, command latch, output decode. No shift register inside.
// TESTING (bench instantiates shift_sequencer + shift register)
//  - Reset low 3 cycles then high -> cmd_ready=1, rsp_valid=0, busy=0; register value unchanged over 10 idle cycles.
//  - cmd {8'hF3, dir=0, count=2} -> rsp_valid after 3 edges, rsp_data=8'hCC.
//  - cmd {8'hF3, dir=1, count=4} -> rsp_data=8'h0F; cmd {8'hA5, count=0} -> rsp_data=8'hA5 after 1 edge.
//  - cmd {8'hFF, dir=0, count=15} -> clamped: 9 edges to rsp_valid, rsp_data=8'h00.
//  - rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0.
//    Then a back-to-back cmd is accepted only after the handshake.
//  - Reset pulsed during SHIFT of {8'h81, dir=1, count=6} -> immediate IDLE, no rsp_valid.
//    Next command completes correctly.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift-register sequencer: FSM states and shift directions.
`timescale 1ns/1ps
package shift_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_seq_counter.sv
// Shift-count down-counter. A requested count above WIDTH is clamped to WIDTH
// when loaded. 'last' flags the final shift cycle and 'zero' flags an empty count.
`timescale 1ns/1ps
module shift_seq_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero,
  output logic             last
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: a load takes priority and clamps; otherwise count down to zero and stop there.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_val > MAX_CNT) ? MAX_CNT : load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Count register; reset clears any partially consumed count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);
  assign last = (cnt_q == ONE);

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven controller for an external left/right shift register.
// Sequence per command: parallel-load, shift 'count' times, then present the
// register contents on the response port. Between commands the register is
// held by reloading its own output.
//
// Handshakes: a transfer occurs on a rising edge where valid and ready are both
// high. The initiator holds its payload stable while valid is high and unaccepted;
// cmd_ready never depends on cmd_valid, and rsp_valid never depends on rsp_ready.
`timescale 1ns/1ps
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic             sr_load_enable,
  output logic             sr_left_right_shift,
  output logic [WIDTH-1:0] sr_i,
  input  logic [WIDTH-1:0] sr_q,
  output logic [1:0]       dbg_state
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic             accept;
  logic             cnt_zero;
  logic             cnt_last;

  // A command is taken only in IDLE and never while reset is asserted.
  assign accept    = cmd_valid && reset && (state_q == ST_IDLE);
  assign dbg_state = state_q;

  shift_seq_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .dec      (state_q == ST_SHIFT),
    .load_val (cmd_count),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  // Next-state, command latch and Moore output decode from registered state.
  always_comb begin
    state_d             = state_q;
    data_d              = data_q;
    dir_d               = dir_q;
    cmd_ready           = 1'b0;
    busy                = 1'b1;
    rsp_valid           = 1'b0;
    rsp_data            = '0;
    sr_load_enable      = 1'b1;
    sr_i                = sr_q;
    sr_left_right_shift = dir_q;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = reset;
        busy      = 1'b0;
        if (accept) begin
          data_d  = cmd_data;
          dir_d   = cmd_dir;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sr_i    = data_q;
        state_d = cnt_zero ? ST_RESP : ST_SHIFT;
      end
      ST_SHIFT: begin
        sr_load_enable = 1'b0;
        state_d        = cnt_last ? ST_RESP : ST_SHIFT;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = sr_q;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and command latch; reset abandons any sequence in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      dir_q   <= DIR_LEFT;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer driving a behavioural 8-bit shift register.
`timescale 1ns/1ps
module tb_shift_sequencer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             cmd_dir = 1'b0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;
  logic             sr_load_enable;
  logic             sr_left_right_shift;
  logic [WIDTH-1:0] sr_i;
  logic [WIDTH-1:0] sr_reg = 8'h5A;
  logic [1:0]       dbg_state;

  int tests = 0;
  int fails = 0;
  logic [WIDTH-1:0] exp_q[$];

  // Clock and reset block
  always #5 clk = ~clk;

  // Behavioural shift register: load, or shift one place with zero fill
  always @(posedge clk) begin
    if (sr_load_enable) sr_reg <= sr_i;
    else if (sr_left_right_shift) sr_reg <= sr_reg >> 1;
    else sr_reg <= sr_reg << 1;
  end

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .reset               (reset),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_data            (cmd_data),
    .cmd_dir             (cmd_dir),
    .cmd_count           (cmd_count),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_data            (rsp_data),
    .busy                (busy),
    .sr_load_enable      (sr_load_enable),
    .sr_left_right_shift (sr_left_right_shift),
    .sr_i                (sr_i),
    .sr_q                (sr_reg),
    .dbg_state           (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for the response, check latency and data against the scoreboard
  task automatic wait_rsp(input int exp_lat);
    int edges;
    logic [WIDTH-1:0] exp_d;
    edges = 0;
    while (!rsp_valid && edges < 40) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check("rsp_valid", rsp_valid, 1);
    check("latency", edges, exp_lat);
    exp_d = exp_q.pop_front();
    check("rsp_data", rsp_data, exp_d);
    check("busy_resp", busy, 1);
    check("cmd_ready_resp", cmd_ready, 0);
  endtask

  // Complete the response handshake and check the return to idle
  task automatic handshake(input logic [WIDTH-1:0] held);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_after_hs", rsp_valid, 0);
    check("rsp_data_idle", rsp_data, 0);
    check("busy_after_hs", busy, 0);
    check("cmd_ready_after_hs", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    check("sr_held_idle", sr_reg, held);
  endtask

  // Offer a command, let it be accepted, then scramble the inputs
  task automatic send_cmd(input logic [WIDTH-1:0] d, input logic dir,
                          input logic [CNT_W-1:0] cnt, input logic [WIDTH-1:0] exp_d);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_dir   = dir;
    cmd_count = cnt;
    check("cmd_ready_idle", cmd_ready, 1);
    exp_q.push_back(exp_d);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = ~d;
    cmd_dir   = ~dir;
    cmd_count = ~cnt;
    check("busy_after_accept", busy, 1);
    check("cmd_ready_after_accept", cmd_ready, 0);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held low for three cycles
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("cmd_ready_in_reset", cmd_ready, 0);
    check("rsp_valid_in_reset", rsp_valid, 0);
    reset = 1'b1;
    #1;
    check("cmd_ready_reset", cmd_ready, 1);
    check("rsp_valid_reset", rsp_valid, 0);
    check("busy_reset", busy, 0);
    check("state_reset", dbg_state, 0);
    repeat (10) @(negedge clk);
    check("sr_hold_10", sr_reg, 8'h5A);

    // F3 left by 2 -> CC after 3 edges, with a 5-cycle response stall
    @(negedge clk);
    send_cmd(8'hF3, 1'b0, 4'd2, 8'hCC);
    wait_rsp(3);
    // Offer the next command while the response is stalled
    cmd_valid = 1'b1;
    cmd_data  = 8'hA5;
    cmd_dir   = 1'b1;
    cmd_count = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp_data", rsp_data, 8'hCC);
      check("stall_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("b2b_state_idle", dbg_state, 0);
    check("b2b_cmd_ready", cmd_ready, 1);
    check("b2b_rsp_valid", rsp_valid, 0);
    exp_q.push_back(8'hA5);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b_state_load", dbg_state, 1);
    wait_rsp(1);
    handshake(8'hA5);

    // F3 right by 4 -> 0F
    send_cmd(8'hF3, 1'b1, 4'd4, 8'h0F);
    wait_rsp(5);
    handshake(8'h0F);

    // A5 with count 0 -> A5 after 1 edge
    send_cmd(8'hA5, 1'b0, 4'd0, 8'hA5);
    wait_rsp(1);
    handshake(8'hA5);

    // FF left by 15 clamps to 8 -> 00 after 9 edges
    send_cmd(8'hFF, 1'b0, 4'd15, 8'h00);
    wait_rsp(9);
    handshake(8'h00);

    // 81 right by 6, reset after the first shift: 81 -> 40, no response
    cmd_valid = 1'b1;
    cmd_data  = 8'h81;
    cmd_dir   = 1'b1;
    cmd_count = 4'd6;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("pre_reset_shift", dbg_state, 2);
    reset = 1'b0;
    #1;
    check("mid_reset_state", dbg_state, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_rsp_valid", rsp_valid, 0);
    check("mid_reset_cmd_ready", cmd_ready, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_no_rsp", rsp_valid, 0);
    end
    reset = 1'b1;
    #1;
    check("partial_held", sr_reg, 8'h40);
    check("post_reset_ready", cmd_ready, 1);
    @(negedge clk);

    // Next command completes normally: 3C right by 1 -> 1E
    send_cmd(8'h3C, 1'b1, 4'd1, 8'h1E);
    wait_rsp(2);
    handshake(8'h1E);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
